// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: time-multiplexed seven-segment scanner with double buffering, guard interval and leading-zero blanking
module sseg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int GUARD          = 2,
  parameter int LZ_SUPPRESS    = 1,
  parameter int ACTIVE_LOW_SEG = 0,
  parameter int ACTIVE_LOW_AN  = 0,
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1,
  localparam int CW = $clog2(REFRESH_DIV)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank,
  output logic [0:6]              led,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IW-1:0]           digit_idx,
  output logic                    frame_done
);
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] shadow_val, disp_val;
  logic [NUM_DIGITS-1:0]   shadow_dp, disp_dp, zero_from;
  logic                    slot_end, frame_end, in_guard, supp, drive, dp_raw;
  logic [3:0]              nib;
  logic [6:0]              glyph;
  logic [NUM_DIGITS-1:0]   an_raw;
  assign slot_end  = cnt == CW'(REFRESH_DIV - 1);
  assign frame_end = slot_end && idx == IW'(NUM_DIGITS - 1);
  // Slot/digit counters; the displayed buffer only changes at the frame wrap so a frame never tears
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      frame_done <= 1'b0;
    end else begin
      cnt        <= slot_end ? '0 : cnt + 1'b1;
      frame_done <= frame_end;
      if (slot_end)
        idx <= frame_end ? '0 : idx + 1'b1;
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
      end
      if (frame_end) begin
        disp_val <= load ? value : shadow_val;
        disp_dp  <= load ? dp_in : shadow_dp;
      end
    end
  end
  // zero_from[i] is set when digit i and every more significant digit hold zero
  always_comb begin
    logic z;
    z         = 1'b1;
    zero_from = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z            = z && disp_val[4*i +: 4] == 4'h0;
      zero_from[i] = z;
    end
  end
  // Hex nibble to segment pattern, a is the MSB
  always_comb begin
    nib   = disp_val[4*idx +: 4];
    glyph = 7'b0000000;
    case (nib)
      4'h0: glyph = 7'b1111110;
      4'h1: glyph = 7'b0110000;
      4'h2: glyph = 7'b1101101;
      4'h3: glyph = 7'b1111001;
      4'h4: glyph = 7'b0110011;
      4'h5: glyph = 7'b1011011;
      4'h6: glyph = 7'b1011111;
      4'h7: glyph = 7'b1110000;
      4'h8: glyph = 7'b1111111;
      4'h9: glyph = 7'b1111011;
      4'hA: glyph = 7'b1110111;
      4'hB: glyph = 7'b0011111;
      4'hC: glyph = 7'b1001110;
      4'hD: glyph = 7'b0111101;
      4'hE: glyph = 7'b1001111;
      4'hF: glyph = 7'b1000111;
      default: glyph = 7'b0000000;
    endcase
  end
  // Drive the current digit outside the guard window unless blanked or a leading zero; polarity applied last
  always_comb begin
    in_guard  = GUARD > 0 && cnt < CW'(GUARD);
    supp      = LZ_SUPPRESS != 0 && idx != '0 && zero_from[idx] && !disp_dp[idx];
    drive     = !in_guard && !blank && !supp;
    an_raw    = drive ? NUM_DIGITS'(1) << idx : '0;
    dp_raw    = drive && disp_dp[idx];
    an        = ACTIVE_LOW_AN != 0 ? ~an_raw : an_raw;
    led       = ACTIVE_LOW_SEG != 0 ? ~(drive ? glyph : 7'b0) : (drive ? glyph : 7'b0);
    dp        = ACTIVE_LOW_SEG != 0 ? ~dp_raw : dp_raw;
    digit_idx = idx;
  end
endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb_sseg_scan_driver: scoreboard bench for the seven-segment scan driver
module tb_sseg_scan_driver;
  localparam int ND = 4, RD = 8, G = 2;
  logic        clk = 1'b0, rst = 1'b1, load = 1'b0, blank = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [0:6]  led, led_n;
  logic        dp, dp_n, fd, fd_n;
  logic [3:0]  an, an_n;
  logic [1:0]  di, di_n;
  int          checks = 0, errors = 0;
  logic [11:0] q[$];
  logic [11:0] e;
  logic [14:0] want;
  bit          ok;

  always #5 clk = ~clk;

  sseg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD(G)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in), .blank(blank),
    .led(led), .dp(dp), .an(an), .digit_idx(di), .frame_done(fd));

  sseg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD(G),
                     .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_AN(1)) dut_n (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in), .blank(blank),
    .led(led_n), .dp(dp_n), .an(an_n), .digit_idx(di_n), .frame_done(fd_n));

  function automatic logic [6:0] gl(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
          7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
          7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    return t[n];
  endfunction

  function automatic logic [11:0] slot_exp(input logic [15:0] v, input logic [3:0] d, input int s);
    logic [15:0] hi;
    hi = v >> (4 * s);
    if (s != 0 && hi == 16'h0 && !d[s]) return 12'b0;
    return {4'(1 << s), gl(v[4*s +: 4]), d[s]};
  endfunction

  task automatic push_frame(input logic [15:0] v, input logic [3:0] d);
    for (int s = 0; s < ND; s++) q.push_back(slot_exp(v, d, s));
  endtask

  task automatic wait_frame(output bit found);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      found = fd;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({an, led, dp, di, fd} !== 15'b0) begin
      errors++; $display("FAIL reset_state got=%b want=0", {an, led, dp, di, fd});
    end
    checks++;
    if ({an_n, led_n, dp_n, di_n, fd_n} !== 15'b111111111111000) begin
      errors++; $display("FAIL reset_inverted got=%b want=111111111111000", {an_n, led_n, dp_n, di_n, fd_n});
    end
    rst = 1'b0;
    for (int i = 0; i < 40 && di != 2'd2; i++) @(negedge clk);
    checks++;
    if (di !== 2'd2) begin
      errors++; $display("FAIL reach_idx2 got=%0d want=2", di);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({an, led, di, fd} !== 14'b0) begin
      errors++; $display("FAIL mid_reset got=%b want=0", {an, led, di, fd});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (an !== 4'b0000) begin
      errors++; $display("FAIL release_guard0 got=%b want=0000", an);
    end
    @(negedge clk);
    checks++;
    if (an !== 4'b0000) begin
      errors++; $display("FAIL release_guard1 got=%b want=0000", an);
    end
    @(negedge clk);
    checks++;
    if ({an, led, dp, di} !== {4'b0001, 7'b1111110, 1'b0, 2'd0}) begin
      errors++; $display("FAIL release_drive got=%b want=%b", {an, led, dp, di}, {4'b0001, 7'b1111110, 1'b0, 2'd0});
    end
  endtask

  task automatic test_digits;
    value = 16'h12AF; dp_in = 4'b0000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    push_frame(16'h12AF, 4'b0000);
    wait_frame(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL digits_frame_timeout got=0 want=1");
    end
    for (int s = 0; s < ND; s++) begin
      e = q.pop_front();
      for (int j = 0; j < RD; j++) begin
        want = {(j < G) ? 12'b0 : e, 2'(s), s == 0 && j == 0};
        checks++;
        if ({an, led, dp, di, fd} !== want) begin
          errors++; $display("FAIL digits s=%0d j=%0d got=%b want=%b", s, j, {an, led, dp, di, fd}, want);
        end
        @(negedge clk);
      end
    end
    checks++;
    if (fd !== 1'b1) begin
      errors++; $display("FAIL frame_period got=%b want=1", fd);
    end
  endtask

  task automatic test_lz;
    for (int c = 0; c < 2; c++) begin
      value = c != 0 ? 16'h0000 : 16'h0040;
      dp_in = c != 0 ? 4'b0100 : 4'b0000;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      push_frame(value, dp_in);
      wait_frame(ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL lz_frame_timeout case=%0d got=0 want=1", c);
      end
      for (int s = 0; s < ND; s++) begin
        e = q.pop_front();
        for (int j = 0; j < RD; j++) begin
          want = {(j < G) ? 12'b0 : e, 2'(s), s == 0 && j == 0};
          checks++;
          if ({an, led, dp, di, fd} !== want) begin
            errors++; $display("FAIL lz case=%0d s=%0d j=%0d got=%b want=%b", c, s, j, {an, led, dp, di, fd}, want);
          end
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    wait_frame(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL b2b_frame_timeout got=0 want=1");
    end
    repeat (16) @(negedge clk);
    q.push_back(slot_exp(16'h0000, 4'b0100, 2));
    q.push_back(slot_exp(16'h0000, 4'b0100, 3));
    value = 16'h1111; dp_in = 4'b0000; load = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k % RD == 0) e = q.pop_front();
      want = {(k % RD < G) ? 12'b0 : e, 2'(2 + k / RD), 1'b0};
      checks++;
      if ({an, led, dp, di, fd} !== want) begin
        errors++; $display("FAIL keep_old k=%0d got=%b want=%b", k, {an, led, dp, di, fd}, want);
      end
      if (k == 15) begin
        value = 16'h2222; load = 1'b1;
      end else load = 1'b0;
      @(negedge clk);
    end
    load = 1'b0;
    push_frame(16'h2222, 4'b0000);
    for (int s = 0; s < ND; s++) begin
      e = q.pop_front();
      for (int j = 0; j < RD; j++) begin
        want = {(j < G) ? 12'b0 : e, 2'(s), s == 0 && j == 0};
        checks++;
        if ({an, led, dp, di, fd} !== want) begin
          errors++; $display("FAIL wrap_bypass s=%0d j=%0d got=%b want=%b", s, j, {an, led, dp, di, fd}, want);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_polarity;
    value = 16'h8888; dp_in = 4'b0000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_frame(ok);
    checks++;
    if ({ok, an_n, led_n, dp_n} !== {1'b1, 4'b1111, 7'b1111111, 1'b1}) begin
      errors++; $display("FAIL inv_guard got=%b want=1111111111111", {ok, an_n, led_n, dp_n});
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({an_n, led_n, dp_n} !== {4'b1110, 7'b0000000, 1'b1}) begin
      errors++; $display("FAIL inv_eight got=%b want=%b", {an_n, led_n, dp_n}, {4'b1110, 7'b0000000, 1'b1});
    end
  endtask

  task automatic test_blank;
    int pulses;
    pulses = 0;
    wait_frame(ok);
    blank = 1'b1;
    #1;
    for (int k = 0; k < 40; k++) begin
      checks++;
      if ({an, led, dp} !== 12'b0) begin
        errors++; $display("FAIL blank k=%0d got=%b want=0", k, {an, led, dp});
      end
      pulses += int'(fd);
      @(negedge clk);
    end
    checks++;
    if (pulses !== 2) begin
      errors++; $display("FAIL blank_pulses got=%0d want=2", pulses);
    end
    blank = 1'b0;
    #1;
    checks++;
    if ({an, di} !== {4'b0000, 2'd1}) begin
      errors++; $display("FAIL resume_guard got=%b want=000001", {an, di});
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({an, led, di} !== {4'b0010, 7'b1111111, 2'd1}) begin
      errors++; $display("FAIL resume_drive got=%b want=%b", {an, led, di}, {4'b0010, 7'b1111111, 2'd1});
    end
    checks++;
    if (q.size() !== 0) begin
      errors++; $display("FAIL scoreboard_left got=%0d want=0", q.size());
    end
  endtask

  initial begin
    test_reset;
    test_digits;
    test_lz;
    test_back_to_back;
    test_polarity;
    test_blank;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
